// File: rtl/dcache_pkg.sv
// Shared types and helpers for the L1 data cache controller.
//   state_t    : controller FSM states
//   data_sel_t : array write-data source select (CPU / MEM / VC)
//   onehot()   : index to one-hot decode, truncated by the caller to the vector width
package dcache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StSwapOut,
    StSwapIn,
    StWbVc,
    StMoveToVc,
    StFill
  } state_t;

  typedef enum logic [1:0] {
    DS_CPU = 2'd0,
    DS_MEM = 2'd1,
    DS_VC  = 2'd2
  } data_sel_t;

  localparam int unsigned OH_MAX = 64;

  // Out-of-range indices shift the bit off the top and yield all zeros.
  function automatic logic [OH_MAX-1:0] onehot(input int unsigned idx);
    return {{(OH_MAX-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/dcache_victim_ctrl_if.sv
// Controller <-> datapath/memory bundle for the victim-cache controller.
//   master : controller side (samples CPU/datapath status, drives loads/selects/pmem requests)
//   slave  : datapath/CPU/pmem side
// Parameters: WAYS (array associativity), VC_ENTRIES (victim cache size), both powers of 2.
interface dcache_victim_ctrl_if
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned VC_ENTRIES = 4
);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned VC_W  = $clog2(VC_ENTRIES);

  // CPU / datapath status
  logic                  mem_read_cpu;
  logic                  mem_write_cpu;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [WAYS-1:0]       valid_out;
  logic [WAYS-1:0]       dirty_out;
  logic [WAY_W-1:0]      lru_way;
  logic                  vc_hit;
  logic [VC_W-1:0]       vc_hit_idx;
  logic [VC_ENTRIES-1:0] vc_valid;
  logic [VC_ENTRIES-1:0] vc_dirty;
  logic [VC_W-1:0]       vc_lru_idx;
  logic                  swap_dirty;
  logic                  pmem_resp;

  // Controller outputs
  logic                  mem_resp_cpu;
  logic [WAYS-1:0]       ld_tag;
  logic [WAYS-1:0]       ld_valid;
  logic [WAYS-1:0]       ld_dirty;
  logic [WAYS-1:0]       ld_data;
  logic                  valid_in;
  logic                  dirty_in;
  data_sel_t             data_sel;
  logic                  ld_lru;
  logic [WAY_W-1:0]      lru_mru_way;
  logic [VC_ENTRIES-1:0] vc_ld;
  logic                  vc_valid_in;
  logic                  vc_dirty_in;
  logic                  vc_lru_upd;
  logic                  pmem_read;
  logic                  pmem_write;
  logic                  wb_src_vc;

  modport master (
    input  mem_read_cpu, mem_write_cpu, hit, hit_way, valid_out, dirty_out, lru_way,
           vc_hit, vc_hit_idx, vc_valid, vc_dirty, vc_lru_idx, swap_dirty, pmem_resp,
    output mem_resp_cpu, ld_tag, ld_valid, ld_dirty, ld_data, valid_in, dirty_in, data_sel,
           ld_lru, lru_mru_way, vc_ld, vc_valid_in, vc_dirty_in, vc_lru_upd,
           pmem_read, pmem_write, wb_src_vc
  );

  modport slave (
    output mem_read_cpu, mem_write_cpu, hit, hit_way, valid_out, dirty_out, lru_way,
           vc_hit, vc_hit_idx, vc_valid, vc_dirty, vc_lru_idx, swap_dirty, pmem_resp,
    input  mem_resp_cpu, ld_tag, ld_valid, ld_dirty, ld_data, valid_in, dirty_in, data_sel,
           ld_lru, lru_mru_way, vc_ld, vc_valid_in, vc_dirty_in, vc_lru_upd,
           pmem_read, pmem_write, wb_src_vc
  );

endinterface

// File: rtl/dcache_perf_counters.sv
// Three free-running event counters for the data cache controller.
// Ports: clk, rst (async, active-high); miss_inc/vc_hit_inc/wb_inc one-cycle event strobes;
//        miss_cnt/vc_hit_cnt/wb_cnt CNT_W-bit counts, wrapping at 2^CNT_W.
module dcache_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss_inc,
  input  logic             vc_hit_inc,
  input  logic             wb_inc,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] vc_hit_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt   <= '0;
      vc_hit_cnt <= '0;
      wb_cnt     <= '0;
    end else begin
      if (miss_inc)   miss_cnt   <= miss_cnt + 1'b1;
      if (vc_hit_inc) vc_hit_cnt <= vc_hit_cnt + 1'b1;
      if (wb_inc)     wb_cnt     <= wb_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_victim_ctrl.sv
// Control FSM for an N-way L1 data cache backed by a fully-associative victim cache.
// Serves array hits in CHECK, swaps VC hits back into the array, refills misses from pmem and
// writes back a dirty VC replacement entry before the evicted array line moves into the VC.
// Ports: clk, rst (async, active-high); bus (dcache_victim_ctrl_if.master) carries all
//        CPU/datapath/pmem handshakes; miss_cnt/vc_hit_cnt/wb_cnt performance counters.
// Build option: define DCACHE_PERF_CNT_EN to enable the counters; otherwise they read 0.
module dcache_victim_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned VC_ENTRIES = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  dcache_victim_ctrl_if.master  bus,
  output logic [CNT_W-1:0]      miss_cnt,
  output logic [CNT_W-1:0]      vc_hit_cnt,
  output logic [CNT_W-1:0]      wb_cnt
);

  state_t state_q, state_d;
  logic   req;
  logic   miss_evt, vc_hit_evt, wb_evt;

  logic [WAYS-1:0]       hit_oh, lru_oh;
  logic [VC_ENTRIES-1:0] vc_hit_oh, vc_lru_oh;

  assign req       = bus.mem_read_cpu | bus.mem_write_cpu;
  assign hit_oh    = WAYS'(onehot(32'(bus.hit_way)));
  assign lru_oh    = WAYS'(onehot(32'(bus.lru_way)));
  assign vc_hit_oh = VC_ENTRIES'(onehot(32'(bus.vc_hit_idx)));
  assign vc_lru_oh = VC_ENTRIES'(onehot(32'(bus.vc_lru_idx)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    miss_evt         = 1'b0;
    vc_hit_evt       = 1'b0;
    wb_evt           = 1'b0;
    bus.mem_resp_cpu = 1'b0;
    bus.ld_tag       = '0;
    bus.ld_valid     = '0;
    bus.ld_dirty     = '0;
    bus.ld_data      = '0;
    bus.valid_in     = 1'b0;
    bus.dirty_in     = 1'b0;
    bus.data_sel     = DS_CPU;
    bus.ld_lru       = 1'b0;
    bus.lru_mru_way  = '0;
    bus.vc_ld        = '0;
    bus.vc_valid_in  = 1'b0;
    bus.vc_dirty_in  = 1'b0;
    bus.vc_lru_upd   = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.wb_src_vc    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) state_d = StCheck;
      end
      StCheck: begin
        if (!req) begin
          state_d = StIdle;
        end else if (bus.hit) begin
          bus.mem_resp_cpu = 1'b1;
          bus.ld_lru       = 1'b1;
          bus.lru_mru_way  = bus.hit_way;
          if (bus.mem_write_cpu) begin
            bus.ld_data  = hit_oh;
            bus.ld_dirty = hit_oh;
            bus.dirty_in = 1'b1;
            bus.data_sel = DS_CPU;
          end
        end else if (bus.vc_hit) begin
          vc_hit_evt = 1'b1;
          state_d    = StSwapOut;
        end else begin
          miss_evt = 1'b1;
          // An empty victim way needs no eviction; otherwise make room in the VC first.
          if (!bus.valid_out[bus.lru_way]) begin
            state_d = StFill;
          end else if (bus.vc_valid[bus.vc_lru_idx] && bus.vc_dirty[bus.vc_lru_idx]) begin
            state_d = StWbVc;
          end else begin
            state_d = StMoveToVc;
          end
        end
      end
      StSwapOut, StMoveToVc: begin
        // Evicted array line goes into the VC; the datapath keeps the old VC entry in its
        // swap buffer on SWAP_OUT.
        bus.vc_ld       = (state_q == StSwapOut) ? vc_hit_oh : vc_lru_oh;
        bus.vc_valid_in = bus.valid_out[bus.lru_way];
        bus.vc_dirty_in = bus.dirty_out[bus.lru_way];
        bus.vc_lru_upd  = 1'b1;
        state_d         = (state_q == StSwapOut) ? StSwapIn : StFill;
      end
      StSwapIn: begin
        bus.ld_tag   = lru_oh;
        bus.ld_data  = lru_oh;
        bus.ld_valid = lru_oh;
        bus.ld_dirty = lru_oh;
        bus.valid_in = 1'b1;
        bus.dirty_in = bus.swap_dirty;
        bus.data_sel = DS_VC;
        state_d      = StCheck;
      end
      StWbVc: begin
        bus.pmem_write = 1'b1;
        bus.wb_src_vc  = 1'b1;
        if (bus.pmem_resp) begin
          wb_evt  = 1'b1;
          state_d = StMoveToVc;
        end
      end
      StFill: begin
        if (bus.pmem_resp) begin
          bus.ld_tag   = lru_oh;
          bus.ld_data  = lru_oh;
          bus.ld_valid = lru_oh;
          bus.ld_dirty = lru_oh;
          bus.valid_in = 1'b1;
          bus.dirty_in = 1'b0;
          bus.data_sel = DS_MEM;
          state_d      = StCheck;
        end else begin
          bus.pmem_read = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  dcache_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk        (clk),
    .rst        (rst),
    .miss_inc   (miss_evt),
    .vc_hit_inc (vc_hit_evt),
    .wb_inc     (wb_evt),
    .miss_cnt   (miss_cnt),
    .vc_hit_cnt (vc_hit_cnt),
    .wb_cnt     (wb_cnt)
  );
`else
  logic unused_evt;
  assign unused_evt = ^{miss_evt, vc_hit_evt, wb_evt};
  assign miss_cnt   = '0;
  assign vc_hit_cnt = '0;
  assign wb_cnt     = '0;
`endif

endmodule
